mmd_counter: RTL and testbench



---
 rtl/mmd_counter.sv | 64 ++++++
 tb/tb_mmd_counter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mmd_counter.sv
// mmd_counter: multi-modulus divider that makes one output period of N clocks per captured divide value.
// Define MMD_DUTY50_EN for a near-50% square wave on div_out instead of a one-cycle pulse.
module mmd_counter #(
    parameter int MIN_DIV = 3,
    parameter int MAX_DIV = 11,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [3:0]       div_val,
    input  logic             clr_err,
    output logic             div_req,
    output logic             div_out,
    output logic             clamp_err,
    output logic [CNT_W-1:0] period_cnt
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state;
    logic [3:0] cnt, n;
    logic lo, hi, load, run_out;
    assign lo = div_val < 4'(MIN_DIV);
    assign hi = div_val > 4'(MAX_DIV);
    assign n = lo ? 4'(MIN_DIV) : hi ? 4'(MAX_DIV) : div_val;
    assign load = en && (state == IDLE || cnt == 4'd0);
    assign div_req = load && !rst;
`ifdef MMD_DUTY50_EN
    logic [3:0] half;
    // Output level for the cycle after a decrement, judged on the next count value.
    assign run_out = (cnt - 4'd1) >= half;
`else
    assign run_out = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= 4'd0;
            div_out <= 1'b0;
            clamp_err <= 1'b0;
            period_cnt <= '0;
`ifdef MMD_DUTY50_EN
            half <= 4'd0;
`endif
        end else begin
            clamp_err <= (load && (lo || hi)) || (clamp_err && !clr_err);
            if (!en) begin
                state <= IDLE;
                cnt <= 4'd0;
                div_out <= 1'b0;
            end else if (load) begin
                state <= RUN;
                cnt <= n - 4'd1;
                div_out <= 1'b1;
                period_cnt <= period_cnt + CNT_W'(1);
`ifdef MMD_DUTY50_EN
                half <= n >> 1;
`endif
            end else begin
                cnt <= cnt - 4'd1;
                div_out <= run_out;
            end
        end
    end
endmodule

// File: tb/tb_mmd_counter.sv
// tb_mmd_counter: randomized self-checking bench; reference model tracks cycles elapsed since each load.
module tb_mmd_counter;
    localparam int CW = 8;
`ifdef MMD_DUTY50_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, en = 1'b0, clr_err = 1'b0;
    logic [3:0] div_val = 4'd0;
    logic div_req, div_out, clamp_err;
    logic [CW-1:0] period_cnt;
    int n_cmp = 0, n_bad = 0;
    bit m_idle = 1'b1, m_err = 1'b0, m_out = 1'b0, exp_req = 1'b0;
    int m_k = 0, m_n = 0, m_cnt = 0;
    logic got_req;

    mmd_counter #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .en(en), .div_val(div_val), .clr_err(clr_err),
        .div_req(div_req), .div_out(div_out), .clamp_err(clamp_err), .period_cnt(period_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit pred_req(input bit e);
        return e && (m_idle || m_k == m_n - 1);
    endfunction

    function automatic int clampv(input int v);
        return v < 3 ? 3 : v > 11 ? 11 : v;
    endfunction

    task automatic model_reset;
        m_idle = 1'b1; m_k = 0; m_n = 0; m_cnt = 0; m_err = 1'b0; m_out = 1'b0;
    endtask

    // Called one time unit after a rising edge; drives inputs, samples div_req, advances the model.
    task automatic cycle(input bit e, input int d, input bit c);
        en = e; div_val = 4'(d); clr_err = c;
        exp_req = pred_req(e);
        #3 got_req = div_req;
        @(posedge clk);
        if (!e) begin
            m_idle = 1'b1; m_out = 1'b0;
        end else if (exp_req) begin
            m_idle = 1'b0; m_n = clampv(d); m_k = 0; m_cnt = (m_cnt + 1) % (1 << CW);
        end else m_k++;
        m_err = (exp_req && (d < 3 || d > 11)) ? 1'b1 : c ? 1'b0 : m_err;
        if (!m_idle) m_out = DUTY ? (m_k < m_n - m_n / 2) : (m_k == 0);
        #1;
    endtask

    task automatic test_reset;
        en = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        n_cmp += 4;
        if (div_req !== 1'b0) begin n_bad++; $display("FAIL reset_req got %b exp 0", div_req); end
        if (div_out !== 1'b0) begin n_bad++; $display("FAIL reset_out got %b exp 0", div_out); end
        if (clamp_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b exp 0", clamp_err); end
        if (period_cnt !== '0) begin n_bad++; $display("FAIL reset_cnt got %0d exp 0", period_cnt); end
        rst = 1'b0; model_reset();
    endtask

    task automatic test_fixed5;
        for (int i = 0; i < 25; i++) begin
            cycle(1'b1, 5, 1'b0);
            n_cmp += 4;
            if (got_req !== exp_req) begin n_bad++; $display("FAIL fixed5_req i=%0d got %b exp %b", i, got_req, exp_req); end
            if (div_out !== m_out) begin n_bad++; $display("FAIL fixed5_out i=%0d got %b exp %b", i, div_out, m_out); end
            if (clamp_err !== m_err) begin n_bad++; $display("FAIL fixed5_err i=%0d got %b exp %b", i, clamp_err, m_err); end
            if (period_cnt !== CW'(m_cnt)) begin n_bad++; $display("FAIL fixed5_cnt i=%0d got %0d exp %0d", i, period_cnt, m_cnt); end
        end
    endtask

    task automatic test_sequence;
        int seq[4] = '{3, 11, 4, 7};
        int idx = 0;
        int d;
        cycle(1'b0, 0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            d = int'($urandom_range(15));
            if (pred_req(1'b1)) begin d = seq[idx % 4]; idx++; end
            cycle(1'b1, d, 1'b0);
            n_cmp += 4;
            if (got_req !== exp_req) begin n_bad++; $display("FAIL seq_req i=%0d got %b exp %b", i, got_req, exp_req); end
            if (div_out !== m_out) begin n_bad++; $display("FAIL seq_out i=%0d got %b exp %b", i, div_out, m_out); end
            if (clamp_err !== m_err) begin n_bad++; $display("FAIL seq_err i=%0d got %b exp %b", i, clamp_err, m_err); end
            if (period_cnt !== CW'(m_cnt)) begin n_bad++; $display("FAIL seq_cnt i=%0d got %0d exp %0d", i, period_cnt, m_cnt); end
        end
    endtask

    task automatic test_clamp;
        int seq[4] = '{2, 13, 5, 0};
        int idx = 0;
        int d;
        bit c, p;
        cycle(1'b0, 0, 1'b0);
        for (int i = 0; i < 30; i++) begin
            p = pred_req(1'b1);
            d = p ? (idx < 4 ? seq[idx] : 15) : 6;
            c = (i == 17) || (p && idx >= 3);
            if (p) idx++;
            cycle(1'b1, d, c);
            n_cmp += 4;
            if (got_req !== exp_req) begin n_bad++; $display("FAIL clamp_req i=%0d got %b exp %b", i, got_req, exp_req); end
            if (div_out !== m_out) begin n_bad++; $display("FAIL clamp_out i=%0d got %b exp %b", i, div_out, m_out); end
            if (clamp_err !== m_err) begin n_bad++; $display("FAIL clamp_err i=%0d got %b exp %b", i, clamp_err, m_err); end
            if (period_cnt !== CW'(m_cnt)) begin n_bad++; $display("FAIL clamp_cnt i=%0d got %0d exp %0d", i, period_cnt, m_cnt); end
        end
    endtask

    task automatic test_enable;
        bit e[20] = '{0,1,1,1,0,0,0,0,1,1,1,1,1,1,1,1,1,1,1,1};
        for (int i = 0; i < 260; i++) begin
            if (i < 20) cycle(e[i], i < 8 ? 9 : 4, 1'b0);
            else cycle($urandom_range(9) != 0, int'($urandom_range(15)), $urandom_range(19) == 0);
            n_cmp += 4;
            if (got_req !== exp_req) begin n_bad++; $display("FAIL en_req i=%0d got %b exp %b", i, got_req, exp_req); end
            if (div_out !== m_out) begin n_bad++; $display("FAIL en_out i=%0d got %b exp %b", i, div_out, m_out); end
            if (clamp_err !== m_err) begin n_bad++; $display("FAIL en_err i=%0d got %b exp %b", i, clamp_err, m_err); end
            if (period_cnt !== CW'(m_cnt)) begin n_bad++; $display("FAIL en_cnt i=%0d got %0d exp %0d", i, period_cnt, m_cnt); end
        end
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 3 * (1 << CW) + 12; i++) begin
            cycle(1'b1, 3, 1'b0);
            n_cmp += 3;
            if (got_req !== exp_req) begin n_bad++; $display("FAIL wrap_req i=%0d got %b exp %b", i, got_req, exp_req); end
            if (div_out !== m_out) begin n_bad++; $display("FAIL wrap_out i=%0d got %b exp %b", i, div_out, m_out); end
            if (period_cnt !== CW'(m_cnt)) begin n_bad++; $display("FAIL wrap_cnt i=%0d got %0d exp %0d", i, period_cnt, m_cnt); end
        end
    endtask

    task automatic test_async_reset;
        cycle(1'b0, 0, 1'b0);
        cycle(1'b1, 15, 1'b0);
        cycle(1'b1, 0, 1'b0);
        #2 rst = 1'b1;
        #1;
        n_cmp += 4;
        if (div_req !== 1'b0) begin n_bad++; $display("FAIL arst_req got %b exp 0", div_req); end
        if (div_out !== 1'b0) begin n_bad++; $display("FAIL arst_out got %b exp 0", div_out); end
        if (clamp_err !== 1'b0) begin n_bad++; $display("FAIL arst_err got %b exp 0", clamp_err); end
        if (period_cnt !== '0) begin n_bad++; $display("FAIL arst_cnt got %0d exp 0", period_cnt); end
        @(posedge clk); #1;
        rst = 1'b0; model_reset();
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 6, 1'b0);
            n_cmp += 3;
            if (got_req !== exp_req) begin n_bad++; $display("FAIL post_req i=%0d got %b exp %b", i, got_req, exp_req); end
            if (div_out !== m_out) begin n_bad++; $display("FAIL post_out i=%0d got %b exp %b", i, div_out, m_out); end
            if (period_cnt !== CW'(m_cnt)) begin n_bad++; $display("FAIL post_cnt i=%0d got %0d exp %0d", i, period_cnt, m_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_fixed5();
        test_sequence();
        test_clamp();
        test_enable();
        test_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
